// File: rtl/match_descpt_feeder.sv
// match_descpt_feeder: fetches groups of 4 image descriptors from a 1-cycle-latency RAM
// onto four held lanes for the match engine. Rev 1.0
`default_nettype none

module match_descpt_feeder #(
  parameter int DW = 403,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] kpt_num,
  input  logic          descriptor_request,
  input  logic [DW-1:0] img_dout,
  output logic          descriptor_valid,
  output logic [DW-1:0] image_R_C_D_0,
  output logic [DW-1:0] image_R_C_D_1,
  output logic [DW-1:0] image_R_C_D_2,
  output logic [DW-1:0] image_R_C_D_3,
  output logic [3:0]    lane_valid,
  output logic [AW-1:0] img_addr,
  output logic          img_re,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_FETCH    = 3'd2,
    S_CAPT     = 3'd3,
    S_VALID    = 3'd4,
    S_DROP     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] kpt_reg;
  logic [AW:0]   ngroups;
  logic [AW:0]   grp;
  logic [AW:0]   base;
  logic [1:0]    k;
  logic [DW-1:0] lane [4];

  logic [AW:0]   fetch_idx;
  logic          fetch_in_range;
  logic [AW:0]   ngroups_sum;

  // One extra bit keeps base+k and the group count exact at kpt_num = 2047.
  assign fetch_idx      = base + {{(AW-1){1'b0}}, k};
  assign fetch_in_range = fetch_idx < {1'b0, kpt_reg};
  assign ngroups_sum    = {1'b0, kpt_num} + (AW+1)'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = (kpt_num == '0) ? S_DONE : S_WAIT_REQ;
      S_WAIT_REQ: if (descriptor_request) state_nxt = S_FETCH;
      S_FETCH:    if (k == 2'd3) state_nxt = S_CAPT;
      S_CAPT:     state_nxt = S_VALID;
      S_VALID:    state_nxt = S_DROP;
      S_DROP:     if (!descriptor_request) state_nxt = (grp == ngroups) ? S_DONE : S_WAIT_REQ;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    descriptor_valid = (state == S_VALID);
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
    img_re           = (state == S_FETCH) && fetch_in_range;
    img_addr         = (state == S_FETCH) ? fetch_idx[AW-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kpt_reg    <= '0;
      ngroups    <= '0;
      grp        <= '0;
      base       <= '0;
      k          <= '0;
      lane_valid <= '0;
      for (int i = 0; i < 4; i++) lane[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            kpt_reg    <= kpt_num;
            ngroups    <= ngroups_sum >> 2;
            grp        <= '0;
            base       <= '0;
            lane_valid <= '0;
            for (int i = 0; i < 4; i++) lane[i] <= '0;
          end
        end
        S_WAIT_REQ: k <= '0;
        S_FETCH: begin
          // RAM data for read k-1 is on img_dout this cycle.
          if (k != 2'd0) lane[k - 2'd1] <= img_dout;
          k <= k + 2'd1;
        end
        S_CAPT: begin
          for (int i = 0; i < 4; i++) begin
            if ((base + (AW+1)'(i)) < {1'b0, kpt_reg}) begin
              lane_valid[i] <= 1'b1;
              if (i == 3) lane[i] <= img_dout;
            end else begin
              lane_valid[i] <= 1'b0;
              lane[i]       <= '0;
            end
          end
        end
        S_VALID: begin
          grp  <= grp + (AW+1)'(1);
          base <= base + (AW+1)'(4);
        end
        default: ;
      endcase
    end
  end

  assign image_R_C_D_0 = lane[0];
  assign image_R_C_D_1 = lane[1];
  assign image_R_C_D_2 = lane[2];
  assign image_R_C_D_3 = lane[3];

endmodule

`default_nettype wire

// File: tb/tb_match_descpt_feeder.sv
// tb_match_descpt_feeder: directed scoreboard bench for match_descpt_feeder. Rev 1.0
`default_nettype none

module tb_match_descpt_feeder;
  localparam int DW = 403;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] kpt_num = '0;
  logic          descriptor_request = 1'b0;
  logic [DW-1:0] img_dout = '0;
  logic          descriptor_valid;
  logic [DW-1:0] image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3;
  logic [3:0]    lane_valid;
  logic [AW-1:0] img_addr;
  logic          img_re;
  logic          busy;
  logic          done;

  match_descpt_feeder #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .kpt_num(kpt_num),
    .descriptor_request(descriptor_request), .img_dout(img_dout),
    .descriptor_valid(descriptor_valid),
    .image_R_C_D_0(image_R_C_D_0), .image_R_C_D_1(image_R_C_D_1),
    .image_R_C_D_2(image_R_C_D_2), .image_R_C_D_3(image_R_C_D_3),
    .lane_valid(lane_valid), .img_addr(img_addr), .img_re(img_re),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Image RAM model: word n holds n+1, synchronous read.
  always @(posedge clk) if (img_re) img_dout <= DW'(img_addr) + DW'(1);

  typedef struct packed {
    logic [3:0][DW-1:0] l;
    logic [3:0]         lv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   re_cnt = 0, valid_cnt = 0, done_cnt = 0;
  int   re0 = 0, v0 = 0, d0 = 0;
  int   cur_kpt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (img_re) begin
      re_cnt++;
      chk("img_re_in_range", DW'(int'(img_addr) < cur_kpt), DW'(1));
    end
    if (done) done_cnt++;
    if (descriptor_valid) begin
      exp_t e;
      valid_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_valid", DW'(1), DW'(0));
      end else begin
        e = q.pop_front();
        chk("lane0", image_R_C_D_0, e.l[0]);
        chk("lane1", image_R_C_D_1, e.l[1]);
        chk("lane2", image_R_C_D_2, e.l[2]);
        chk("lane3", image_R_C_D_3, e.l[3]);
        chk("lane_valid", DW'(lane_valid), DW'(e.lv));
      end
    end
  end

  task automatic start_session(input int kn, input bit accepted);
    @(posedge clk); #1;
    start = 1'b1; kpt_num = AW'(kn);
    if (accepted) begin
      cur_kpt = kn; re0 = re_cnt; v0 = valid_cnt; d0 = done_cnt;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fetch_group(input int w0, w1, w2, w3, input logic [3:0] lv, input bit drop);
    exp_t e;
    int n;
    e.l[0] = DW'(w0); e.l[1] = DW'(w1); e.l[2] = DW'(w2); e.l[3] = DW'(w3); e.lv = lv;
    q.push_back(e);
    descriptor_request = 1'b1;
    n = 0;
    @(negedge clk);
    while (!descriptor_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("valid_latency", DW'(n), DW'(6));
    if (drop) begin
      @(posedge clk); #1 descriptor_request = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic end_session(input int exp_re, input int exp_valid);
    @(negedge clk);
    chk("done_pulse", DW'(done), DW'(1));
    @(negedge clk);
    chk("done_cleared", DW'(done), DW'(0));
    chk("idle_not_busy", DW'(busy), DW'(0));
    chk("read_count", DW'(re_cnt - re0), DW'(exp_re));
    chk("valid_count", DW'(valid_cnt - v0), DW'(exp_valid));
    chk("done_count", DW'(done_cnt - d0), DW'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, DW'(descriptor_valid), DW'(0));
    chk({tag, "_img_re"}, DW'(img_re), DW'(0));
    chk({tag, "_img_addr"}, DW'(img_addr), DW'(0));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
    chk({tag, "_lane_valid"}, DW'(lane_valid), DW'(0));
    chk({tag, "_lane0"}, image_R_C_D_0, DW'(0));
    chk({tag, "_lane3"}, image_R_C_D_3, DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Eight keypoints: two full groups.
    start_session(8, 1'b1);
    @(negedge clk);
    chk("busy_after_start", DW'(busy), DW'(1));
    @(posedge clk); #1;
    fetch_group(1, 2, 3, 4, 4'b1111, 1'b1);
    fetch_group(5, 6, 7, 8, 4'b1111, 1'b1);
    end_session(8, 2);

    // Six keypoints: partial last group, start clears held lanes.
    start_session(6, 1'b1);
    @(negedge clk);
    chk("start_clears_lane_valid", DW'(lane_valid), DW'(0));
    chk("start_clears_lane0", image_R_C_D_0, DW'(0));
    @(posedge clk); #1;
    fetch_group(1, 2, 3, 4, 4'b1111, 1'b1);
    fetch_group(5, 6, 0, 0, 4'b0011, 1'b1);
    end_session(6, 2);

    // Zero keypoints: straight to done.
    start_session(0, 1'b1);
    end_session(0, 0);

    // Request held high long after valid: a single fetch only.
    start_session(8, 1'b1);
    fetch_group(1, 2, 3, 4, 4'b1111, 1'b0);
    repeat (10) @(negedge clk);
    chk("held_req_valid_count", DW'(valid_cnt - v0), DW'(1));
    chk("held_req_read_count", DW'(re_cnt - re0), DW'(4));
    chk("held_req_lanes_stable", image_R_C_D_1, DW'(2));
    @(posedge clk); #1 descriptor_request = 1'b0;
    @(posedge clk); #1;
    fetch_group(5, 6, 7, 8, 4'b1111, 1'b1);
    end_session(8, 2);

    // Asynchronous reset in the middle of a fetch.
    start_session(8, 1'b1);
    descriptor_request = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    descriptor_request = 1'b0;
    #1;
    chk_all_zero("midfetch_reset");
    q.delete();
    v0 = valid_cnt;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_valid_after_reset", DW'(valid_cnt - v0), DW'(0));
    start_session(4, 1'b1);
    fetch_group(1, 2, 3, 4, 4'b1111, 1'b1);
    end_session(4, 1);

    // Start while busy is ignored; the session still ends after two groups.
    start_session(8, 1'b1);
    fetch_group(1, 2, 3, 4, 4'b1111, 1'b1);
    start = 1'b1; kpt_num = AW'(20);
    @(posedge clk); #1 start = 1'b0;
    fetch_group(5, 6, 7, 8, 4'b1111, 1'b1);
    end_session(8, 2);

    chk("scoreboard_drained", DW'(q.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
